serial_add_ctrl: RTL

- Bit-serial add/subtract sequencer that time-shares one external one-bit full-adder cell (three input bits in, sum and carry-out back) across WIDTH clock cycles.
- It latches two WIDTH-bit operands on a START handshake and feeds the cell LSB-first, keeping the carry in a flip-flop.
- It shifts the sum bits into a result register and reports SUM, COUT and signed OVF with a one-cycle DONE pulse.
- It sits between the board-level operand/control logic and the shared full-adder datapath cell.

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared external full-adder cell.
// Operands are fed LSB-first over WIDTH cycles; the result is reported with a DONE pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             FA_X0,
  output logic             FA_X1,
  output logic             FA_X2,
  input  logic             FA_F,
  input  logic             FA_COUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  assign w_run      = (r_state == S_RUN);
  assign w_accept   = (r_state == S_IDLE) && START;
  assign w_last     = w_run && (r_cnt == LAST);
  assign w_sum_next = {FA_F, r_sum_sh};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    FA_X0  = 1'b0;
    FA_X1  = 1'b0;
    FA_X2  = 1'b0;
    case (r_state)
      S_IDLE: if (START) w_next = S_RUN;
      S_RUN: begin
        BUSY  = 1'b1;
        FA_X0 = r_a_sh[0];
        FA_X1 = r_b_sh[0];
        FA_X2 = r_carry;
        if (r_cnt == LAST) w_next = S_FIN;
      end
      S_FIN: begin
        BUSY   = 1'b1;
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at load and seed the carry with SUB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= A;
      r_b_sh  <= SUB ? ~B : B;
      r_carry <= SUB;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_next[WIDTH-1:1];
      r_carry  <= FA_COUT;
      if (w_last) begin
        r_cnt  <= '0;
        r_sum  <= w_sum_next;
        r_cout <= FA_COUT;
        // Signed overflow: carry into the MSB differs from carry out of it.
        r_ovf  <= FA_COUT ^ r_carry;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign SUM  = r_sum;
  assign COUT = r_cout;
  assign OVF  = r_ovf;

endmodule
